// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared widths, default error data and FSM state encoding
//               for the pipeline memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [DATA_W-1:0] DEF_ERR_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_stage_wdog.sv
`default_nettype none
// ============================================================================
// Module      : mem_wdog
// Description : Access watchdog; counts enabled cycles since the last clear
//               and flags expiry on the TIMEOUT-th enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] c_LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Fires during the cycle that would be the TIMEOUT-th un-acknowledged one.
  assign expired_o = en_i & (cnt_q >= c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage with req/ready data-memory
//               handshake, timeout watchdog and MEM/WB bubble insertion.
//               Optional stall-cycle counter enabled by MEM_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_hlt,
  input  logic              in_WriteReg,
  input  logic [REG_W-1:0]  in_DstReg,
  input  logic [DATA_W-1:0] in_DstData,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              memwb_en,
  output logic              d_hlt,
  output logic              d_from_mem,
  output logic              d_WriteReg,
  output logic [REG_W-1:0]  d_DstReg,
  output logic [DATA_W-1:0] d_MemData,
  output logic [DATA_W-1:0] d_DstData,
  output logic              mem_err,
  output logic [15:0]       stall_cycles
);

  state_e              state_q;
  logic                req_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                hlt_q;
  logic                wreg_q;
  logic [REG_W-1:0]    dst_q;
  logic [DATA_W-1:0]   dstdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                w_mem_op;
  logic                w_expired;

  assign w_mem_op = in_valid & (in_mem_rd | in_mem_wr);

  mem_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == IDLE),
    .en_i      ((state_q == REQ) & ~mem_ready),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hlt_q     <= 1'b0;
      wreg_q    <= 1'b0;
      dst_q     <= '0;
      dstdata_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_mem_op) begin
            // A simultaneous rd+wr is resolved as a store.
            we_q      <= in_mem_wr;
            addr_q    <= in_addr;
            wdata_q   <= in_wdata;
            hlt_q     <= in_hlt;
            wreg_q    <= in_WriteReg;
            dst_q     <= in_DstReg;
            dstdata_q <= in_DstData;
            req_q     <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            rdata_q <= mem_rdata;
            req_q   <= 1'b0;
            state_q <= RESP;
          end else if (w_expired) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall      = 1'b0;
    d_hlt      = 1'b0;
    d_from_mem = 1'b0;
    d_WriteReg = 1'b0;
    d_DstReg   = '0;
    d_DstData  = '0;
    d_MemData  = '0;
    case (state_q)
      IDLE: begin
        if (w_mem_op) begin
          // Held low under reset so an abandoned access releases the pipe at once.
          stall = ~rst;
        end else begin
          d_hlt      = in_valid & in_hlt;
          d_WriteReg = in_valid & in_WriteReg;
          d_DstReg   = in_DstReg;
          d_DstData  = in_DstData;
        end
      end
      REQ: begin
        stall = 1'b1;
      end
      RESP: begin
        d_hlt      = hlt_q;
        d_WriteReg = wreg_q;
        d_DstReg   = dst_q;
        d_DstData  = dstdata_q;
        d_from_mem = ~we_q;
        d_MemData  = rdata_q;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign memwb_en  = 1'b1;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_err   = err_q;

`ifdef MEM_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule
`default_nettype wire
